// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package serial_sub_pkg;

  localparam int SERIAL_SUB_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor cell: d = x - y - bin, with the borrow out in bo.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bin;
  assign bo = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (A - B, LSB first) behind a start/busy/done handshake.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SERIAL_SUB_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  state_t           state_r;
  logic [WIDTH-1:0] a_sr_r;
  logic [WIDTH-1:0] b_sr_r;
  logic [WIDTH-1:0] res_sr_r;
  logic             borrow_r;
  logic [CW-1:0]    count_r;
  logic             d_s;
  logic             bo_s;
`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb_r;
  logic             b_msb_r;
`endif

  full_subtractor u_cell (
    .x  (a_sr_r[0]),
    .y  (b_sr_r[0]),
    .bin(borrow_r),
    .d  (d_s),
    .bo (bo_s)
  );

  // FSM, operand/result shift registers and registered handshake/result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      a_sr_r   <= {WIDTH{1'b0}};
      b_sr_r   <= {WIDTH{1'b0}};
      res_sr_r <= {WIDTH{1'b0}};
      borrow_r <= 1'b0;
      count_r  <= {CW{1'b0}};
      busy     <= 1'b0;
      done     <= 1'b0;
      diff     <= {WIDTH{1'b0}};
      bout     <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_r  <= 1'b0;
      b_msb_r  <= 1'b0;
      ovf      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            a_sr_r   <= a;
            b_sr_r   <= b;
            borrow_r <= 1'b0;
            count_r  <= {CW{1'b0}};
            busy     <= 1'b1;
            state_r  <= SHIFT;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_r  <= a[WIDTH-1];
            b_msb_r  <= b[WIDTH-1];
`endif
          end else begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        SHIFT: begin
          a_sr_r   <= {1'b0, a_sr_r[WIDTH-1:1]};
          b_sr_r   <= {1'b0, b_sr_r[WIDTH-1:1]};
          res_sr_r <= {d_s, res_sr_r[WIDTH-1:1]};
          borrow_r <= bo_s;
          count_r  <= count_r + CNT_ONE;
          // The current cell output is the MSB, so it is folded straight into diff.
          if (count_r == LAST_BIT) begin
            diff    <= {d_s, res_sr_r[WIDTH-1:1]};
            bout    <= bo_s;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_r <= DONE;
`ifdef SERIAL_SUB_OVF_EN
            ovf     <= (a_msb_r != b_msb_r) && (d_s != a_msb_r);
`endif
          end else begin
            busy    <= 1'b1;
            state_r <= SHIFT;
          end
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
